// File: rtl/apf_cart_mapper_if.sv
// Loader (ioctl) and CPU-side bus bundle for the cartridge mapper.
interface apf_cart_mapper_if #(
  parameter int SLOTS = 2
);
  logic             ioctl_download;
  logic [7:0]       ioctl_index;
  logic             ioctl_wr;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic [15:0]      cpu_addr;
  logic             cpu_rd;
  logic [1:0]       cpu_slot;
  logic [7:0]       cpu_dout;
  logic             cpu_hit;
  logic             cpu_hold;
  logic [SLOTS-1:0] loaded;
  logic             load_done;
  logic             overflow;
  logic [7:0]       checksum;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_addr, cpu_rd, cpu_slot,
    input  cpu_dout, cpu_hit, cpu_hold, loaded, load_done, overflow, checksum
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_addr, cpu_rd, cpu_slot,
    output cpu_dout, cpu_hit, cpu_hold, loaded, load_done, overflow, checksum
  );
endinterface

// File: rtl/apf_cart_mapper.sv
// Multi-slot cartridge image store: ioctl loader with power-of-two padding
// and a mirrored CPU read window.
module apf_cart_mapper #(
  parameter int          AW         = 13,
  parameter int          SLOTS      = 2,
  parameter int          INDEX_BASE = 1,
  parameter logic [15:0] WIN_BASE   = 16'h8000,
  parameter logic [7:0]  FILL       = 8'hFF
) (
  input  logic               clk_sys,
  input  logic               reset,
  apf_cart_mapper_if.slave   bus
);
  localparam int          SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int          DEPTH = SLOTS << AW;
  localparam int unsigned NSLOT = SLOTS;

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]       mem [DEPTH];
  logic             dl_q, rise, fall;
  logic             idx_ok, wr_ok, pad_wr, mem_we;
  logic [SW-1:0]    slot, slot_in, rd_slot, rd_sel;
  logic             slot_ok, hit, rd_ok, hit_q;
  logic [AW:0]      len, len_nx, addr_len, pad_ptr, pad_size;
  logic [AW-1:0]    mask [SLOTS];
  logic [SLOTS-1:0] loaded;
  logic             overflow;
  logic [7:0]       checksum, wdata, rd_q;
  logic [SW+AW-1:0] waddr, raddr;

  assign rise     = bus.ioctl_download & ~dl_q;
  assign fall     = ~bus.ioctl_download & dl_q;
  assign idx_ok   = (32'(bus.ioctl_index) >= 32'(INDEX_BASE)) &&
                    (32'(bus.ioctl_index) <  32'(INDEX_BASE + SLOTS));
  assign slot_in  = SW'(bus.ioctl_index - 8'(INDEX_BASE));
  assign wr_ok    = (state == LOAD) && bus.ioctl_wr && (bus.ioctl_addr[24:AW] == '0);
  assign addr_len = {1'b0, bus.ioctl_addr[AW-1:0]} + (AW+1)'(1);
  assign len_nx   = (wr_ok && addr_len > len) ? addr_len : len;
  assign pad_wr   = (state == PAD) && (len != '0) && (pad_ptr < pad_size);
  assign mem_we   = wr_ok | pad_wr;
  assign waddr    = {slot, (state == PAD) ? pad_ptr[AW-1:0] : bus.ioctl_addr[AW-1:0]};
  assign wdata    = (state == PAD) ? FILL : bus.ioctl_dout;

  // Smallest power of two covering the image, never below one byte.
  always_comb begin
    pad_size = (AW+1)'(1);
    for (int unsigned i = 0; i < AW; i++)
      if (pad_size < len) pad_size = pad_size << 1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise && idx_ok) state_nx = LOAD;
      LOAD:    if (fall) state_nx = PAD;
      PAD:     if (!pad_wr) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q     <= 1'b0;
      slot     <= '0;
      len      <= '0;
      pad_ptr  <= '0;
      loaded   <= '0;
      overflow <= 1'b0;
      checksum <= '0;
      rd_ok    <= 1'b0;
      hit_q    <= 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) mask[i] <= '0;
    end else begin
      dl_q <= bus.ioctl_download;
      case (state)
        IDLE: if (rise && idx_ok) begin
          slot             <= slot_in;
          loaded[slot_in]  <= 1'b0;
          len              <= '0;
          overflow         <= 1'b0;
          checksum         <= '0;
        end
        LOAD: begin
          len     <= len_nx;
          // Padding starts from the length including a write coincident with the fall.
          pad_ptr <= len_nx;
          if (wr_ok)             checksum <= checksum + bus.ioctl_dout;
          else if (bus.ioctl_wr) overflow <= 1'b1;
        end
        PAD: begin
          if (pad_wr)           pad_ptr    <= pad_ptr + (AW+1)'(1);
          else if (len != '0)   mask[slot] <= AW'(pad_size - (AW+1)'(1));
          else                  mask[slot] <= '0;
        end
        DONE: loaded[slot] <= (len != '0);
        default: ;
      endcase
      if (bus.cpu_rd) begin
        hit_q <= hit;
        rd_ok <= hit && slot_ok && loaded[rd_sel] && (state == IDLE);
      end
    end
  end

  assign rd_slot = bus.cpu_slot[SW-1:0];
  assign slot_ok = 32'(bus.cpu_slot) < 32'(SLOTS);
  assign rd_sel  = slot_ok ? rd_slot : '0;
  assign hit     = bus.cpu_rd && (bus.cpu_addr[15:AW] == WIN_BASE[15:AW]);
  assign raddr   = {rd_sel, bus.cpu_addr[AW-1:0] & mask[rd_sel]};

  // Loader writes win the single port; reads in that cycle are reported as FILL anyway.
  always_ff @(posedge clk_sys) begin
    if (mem_we)          mem[waddr] <= wdata;
    else if (bus.cpu_rd) rd_q       <= mem[raddr];
  end

  assign bus.cpu_dout  = rd_ok ? rd_q : FILL;
  assign bus.cpu_hit   = hit_q;
  assign bus.cpu_hold  = (state != IDLE);
  assign bus.loaded    = loaded;
  assign bus.load_done = (state == DONE);
  assign bus.overflow  = overflow;
  assign bus.checksum  = checksum;
endmodule

// File: tb/tb_apf_cart_mapper.sv
// Randomized bench for apf_cart_mapper against a slot-image reference model.
module tb_apf_cart_mapper;
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  apf_cart_mapper_if #(.SLOTS(2)) bus();

  apf_cart_mapper #(
    .AW(13), .SLOTS(2), .INDEX_BASE(1), .WIN_BASE(16'h8000), .FILL(8'hFF)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit [7:0] mdl [2][8192];
  bit       m_loaded [2];
  int       m_mask [2];
  bit       m_ovf;
  int       m_sum;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_read(input int s, input int a);
    if ((a >> 13) != 4 || s >= 2 || !m_loaded[s]) return 255;
    return int'(mdl[s][(a & 8191) & m_mask[s]]);
  endfunction

  function automatic int model_loaded();
    return (m_loaded[1] ? 2 : 0) + (m_loaded[0] ? 1 : 0);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_read(input int s, input int a, input string tag);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = a[15:0];
    bus.cpu_slot = s[1:0];
    tick();
    bus.cpu_rd = 1'b0;
    check(tag, int'(bus.cpu_dout), model_read(s, a));
    check({tag, "_hit"}, int'(bus.cpu_hit), ((a >> 13) == 4) ? 1 : 0);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      int s, a;
      s = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom & 32'hFFFF)
                                      : 32'h8000 + int'($urandom_range(0, 8191));
      cpu_read(s, a, "rand_rd");
    end
  endtask

  task automatic do_load(input int idx, input int n, input bit pattern, input int abort_at);
    bit       in_range;
    int       s, sum, len, p, pad, cyc;
    bit       seen;
    bit [7:0] b;
    bit [7:0] img [8192];
    in_range = (idx >= 1 && idx <= 2);
    s   = idx - 1;
    sum = 0;
    bus.ioctl_index    = idx[7:0];
    bus.ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < n; a++) begin
      b = pattern ? a[7:0] : 8'($urandom);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = a[24:0];
      bus.ioctl_dout = b;
      bus.cpu_rd     = 1'b1;
      bus.cpu_addr   = 16'h8005;
      bus.cpu_slot   = 2'd0;
      tick();
      if (a < 8192) begin
        img[a] = b;
        sum = (sum + int'(b)) & 255;
      end
      if (a == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_hold", int'(bus.cpu_hold), 0);
        bus.ioctl_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        m_loaded[0] = 1'b0; m_loaded[1] = 1'b0;
        m_mask[0] = 0; m_mask[1] = 0;
        m_ovf = 1'b0; m_sum = 0;
        tick();
        check("abort_loaded", int'(bus.loaded), 0);
        check("abort_hold2", int'(bus.cpu_hold), 0);
        return;
      end
      if (a % 1024 == 7) begin
        check("load_hold", int'(bus.cpu_hold), in_range ? 1 : 0);
        check("load_dout", int'(bus.cpu_dout), in_range ? 255 : model_read(0, 16'h8005));
      end
    end
    bus.ioctl_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    bus.ioctl_download = 1'b0;

    len = (n < 8192) ? n : 8192;
    p = 1;
    while (p < len) p = p * 2;
    pad = (len > 0) ? p - len : 0;

    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < pad + 50) begin
      tick();
      cyc++;
      if (bus.load_done) seen = 1'b1;
    end

    if (in_range) begin
      check("done_seen", int'(seen), 1);
      check("pad_cycles", cyc, pad + 2);
      check("done_hold", int'(bus.cpu_hold), 1);
      for (int a = 0; a < len; a++) mdl[s][a] = img[a];
      for (int a = len; a < p && len > 0; a++) mdl[s][a] = 8'hFF;
      m_mask[s]   = (len > 0) ? p - 1 : 0;
      m_loaded[s] = (len > 0);
      m_ovf       = (n > 8192);
      m_sum       = sum;
      tick();
      check("done_pulse", int'(bus.load_done), 0);
    end else begin
      check("oor_no_done", int'(seen), 0);
    end
    check("post_hold", int'(bus.cpu_hold), 0);
    check("loaded", int'(bus.loaded), model_loaded());
    check("overflow", int'(bus.overflow), int'(m_ovf));
    check("checksum", int'(bus.checksum), m_sum);
  endtask

  initial begin
    int v;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = '0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.cpu_addr = '0;
    bus.cpu_rd = 1'b0;
    bus.cpu_slot = '0;
    m_loaded[0] = 1'b0; m_loaded[1] = 1'b0;
    m_mask[0] = 0; m_mask[1] = 0;
    m_ovf = 1'b0; m_sum = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_dout", int'(bus.cpu_dout), 255);
    check("rst_hit", int'(bus.cpu_hit), 0);
    check("rst_hold", int'(bus.cpu_hold), 0);
    check("rst_loaded", int'(bus.loaded), 0);
    check("rst_done", int'(bus.load_done), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_sum", int'(bus.checksum), 0);

    cpu_read(0, 32'h8005, "unloaded_rd");
    cpu_read(0, 32'h4000, "outside_rd");

    do_load(1, 8192, 1'b1, -1);
    check("pattern_sum", int'(bus.checksum), 0);
    check("pattern_loaded", int'(bus.loaded), 1);
    cpu_read(0, 32'h8005, "rd_8005");
    check("rd_8005_val", int'(bus.cpu_dout), 5);

    do_load(2, 3000, 1'b0, -1);
    cpu_read(1, 32'h8BB8, "pad_byte");
    check("pad_byte_val", int'(bus.cpu_dout), 255);
    cpu_read(1, 32'h9005, "mirror_hi");
    v = int'(bus.cpu_dout);
    cpu_read(1, 32'h8005, "mirror_lo");
    check("mirror_eq", int'(bus.cpu_dout), v);
    random_reads(40);

    do_load(2, 8200, 1'b0, -1);
    check("ovf_set", int'(bus.overflow), 1);
    random_reads(30);

    do_load(5, 64, 1'b0, -1);

    do_load(1, 4096, 1'b0, 2000);
    cpu_read(0, 32'h8005, "after_abort_rd");
    do_load(1, 4000, 1'b0, -1);
    random_reads(40);

    do_load(2, 0, 1'b0, -1);
    cpu_read(1, 32'h8000, "empty_rd");
    do_load(2, 1, 1'b0, -1);
    random_reads(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
